sao_band_window_search: RTL and testbench
=========================================

# sao_band_window_search

Parametrised successor to the SAO band-offset distortion accumulator. It takes a stream of per-category signed distortions and, in BO mode, forms the sliding sum of every WIN consecutive bands. In EO mode it forms aligned WIN-category sums, one per EO class. It reports every window sum and the minimum-distortion start position, and it sits between the per-category distortion calculator and the SAO mode decision.

## Interface
Parameters:
- DIST_W, 21: signed width of one category distortion.
- WIN, 4: categories per window (HEVC: 4).
- NUM_BAND, 32: BO bands per pass.
- NUM_EO_CLASS, 4: EO classes per pass.
- Derived, not overridable:
  - SUM_W = DIST_W + $clog2(WIN).
  - POS_W = $clog2(max(NUM_BAND, NUM_EO_CLASS)).

Ports:
- clk, in, 1: clock. One clock only.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begins a pass. Sampled only in IDLE.
- mode, in, 1: 0 = BO (sliding windows), 1 = EO (aligned windows). Latched on start.
- in_valid, in, 1: in_dist is valid.
- in_dist, in, DIST_W signed: category distortion. Categories arrive in ascending order.
- in_ready, out, 1: block accepts data. 1 only in RUN.
- win_valid, out, 1: one-cycle strobe; win_sum/win_pos valid.
- win_sum, out, SUM_W signed: window sum.
- win_pos, out, POS_W: BO start band, or EO class index.
- best_valid, out, 1: one-cycle strobe at end of pass.
- best_sum, out, SUM_W signed: minimum window sum.
- best_pos, out, POS_W: position of best_sum.
- busy, out, 1: state != IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. start in any other state is ignored.
  - RUN -> DRAIN on acceptance of the last sample.
  - DRAIN -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Pass length N: NUM_BAND in BO mode; NUM_EO_CLASS*WIN in EO mode.
- An accept is in_valid && in_ready. in_valid outside RUN is ignored. Bubbles, i.e. in_valid low in RUN, stall the pass with no side effects.
- Sample counter idx runs 0..N-1 and increments per accept. It clears on start.
- On start, clear:
  - the WIN-deep shift register;
  - idx;
  - a "first candidate" flag (set to 1);
  - best_sum and best_pos.
- BO emission: every accept with idx >= WIN-1 emits a window of the last WIN samples, with win_pos = idx-WIN+1. This gives NUM_BAND-WIN+1 emissions per pass.
- EO emission: every accept with idx%WIN == WIN-1 emits the last WIN samples, with win_pos = idx/WIN. This gives NUM_EO_CLASS emissions per pass.
- Arithmetic:
  - Sums are at full width SUM_W, sign-extended; no saturation and no overflow is possible.
  - Comparison is signed.
- Best update, on each emitted window:
  - If the first-candidate flag is set, or win_sum < best_sum (strict), load best_sum/best_pos and clear the flag.
  - Ties keep the lower position.
- best_sum/best_pos hold their value after DONE until the next start or rst.
- rst in any state returns all state and outputs to reset values on the next edge. A partial pass is discarded.

## Timing
- Reset values: in_ready 0, win_valid 0, win_sum 0, win_pos 0, best_valid 0, best_sum 0, best_pos 0, busy 0. State is IDLE.
- start sampled at edge e: RUN is visible after e, and in_ready=1 from that cycle.
- Accept at cycle t: win_valid/win_sum/win_pos are registered and visible in cycle t+1. They are deasserted in t+1 if no window is emitted.
- The best register is updated at the end of t+1, so it is visible at t+2.
- Last accept at t:
  - DRAIN in t+1, with the final win_valid;
  - DONE in t+2, with best_valid=1 and final best values;
  - IDLE in t+3, busy=0.
- start in the same cycle as DONE is ignored. The earliest new start is sampled in IDLE at t+3.
- in_ready drops to 0 in DRAIN. No sample beyond N is ever accepted.

## Structure
- Package sao_pkg:
  - state enum;
  - mode enum (SAO_BO, SAO_EO);
  - helper function for the derived POS_W/SUM_W.
- Sub-module sao_win_sum, parametrised by DIST_W and WIN:
  - WIN-deep shift register with shift enable;
  - balanced adder tree;
  - registered output.
- The top level holds the FSM, idx, the emission decode and the best comparator.

## Test plan
Defaults: WIN=4, NUM_BAND=32, DIST_W=21, unless stated.
- BO dip: in_dist=10, except bands 5..8 = -100, no bubbles.
  - Exactly 29 win_valid.
  - win_sum at pos 0 = 40.
  - best_pos=5, best_sum=-400.
  - best_valid exactly 2 cycles after last accept.
- BO tie: all in_dist=0 -> best_pos=0, best_sum=0, 29 win_valid with win_pos 0..28 in order.
- EO: mode=1, 16 samples whose class sums are {5,-3,-3,7} -> 4 win_valid with win_pos 0..3, best_pos=1, best_sum=-3.
- Bubbles: the BO dip stream with in_valid toggling every cycle -> identical win sequence and best result, and in_ready=0 after the 32nd accept.
- Reset mid-pass: rst for 1 cycle after 10 accepts -> all outputs zero and busy=0 next cycle. Then a new BO dip pass gives best_pos=5, best_sum=-400.
- Extremes: all in_dist = -2^20 -> every win_sum = -2^22 with no wrap, best_pos=0. With all in_dist = 2^20-1, best_sum = 4*(2^20-1).

Source files
------------

// File: rtl/sao_pkg.sv
// Shared types and width helpers for the SAO band/EO window search.
// Holds the pass FSM state encoding and the BO/EO mode encoding.
// Width helpers keep SUM_W/POS_W derivation in one place.
package sao_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sao_state_e;

  typedef enum logic {
    SAO_BO = 1'b0,
    SAO_EO = 1'b1
  } sao_mode_e;

  // Sum of WIN signed values needs clog2(WIN) guard bits.
  function automatic int sao_sum_w(input int dist_w, input int win);
    return dist_w + $clog2(win);
  endfunction

  // Position field must index the larger of the band and class ranges.
  function automatic int sao_pos_w(input int num_band, input int num_eo_class);
    return $clog2((num_band > num_eo_class) ? num_band : num_eo_class);
  endfunction

endpackage

// File: rtl/sao_win_sum.sv
// Window summer: shift history plus balanced adder tree over the last WIN samples.
// Latency 1: the sum including the sample shifted in at edge e is visible after e.
// No backpressure; shift_i is the accept strobe from the owner.
module sao_win_sum import sao_pkg::*; #(
  parameter int  DIST_W = 21,
  parameter int  WIN    = 4,
  localparam int SUM_W  = sao_sum_w(DIST_W, WIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     shift_i,
  input  logic signed [DIST_W-1:0] din_i,
  output logic signed [SUM_W-1:0]  sum_o
);

  // The incoming sample is the head of the window, so only WIN-1 older
  // samples need to be stored to form a full WIN-wide sum.
  localparam int HIST   = (WIN > 1) ? WIN - 1 : 1;
  localparam int LEAVES = 1 << $clog2(WIN);

  logic signed [DIST_W-1:0] hist_q [HIST];
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  node [2*LEAVES-1];

  // Leaves of the tree: newest sample, then history, zero padding to a power of two.
  for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
    if (g == 0) begin : g_head
      assign node[LEAVES-1] = SUM_W'(din_i);
    end else if (g < WIN) begin : g_hist
      assign node[LEAVES-1+g] = SUM_W'(hist_q[g-1]);
    end else begin : g_pad
      assign node[LEAVES-1+g] = '0;
    end
  end

  // Internal nodes: each adds its two children, giving a log2 depth tree.
  for (genvar g = 0; g < LEAVES - 1; g++) begin : g_add
    assign node[g] = node[2*g+1] + node[2*g+2];
  end

  assign sum_d = node[0];
  assign sum_o = sum_q;

  // Shift history and capture the window sum on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hist_q <= '{default: '0};
      sum_q  <= '0;
    end else if (shift_i) begin
      hist_q[0] <= din_i;
      for (int k = 1; k < HIST; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/sao_band_window_search.sv
// SAO window search: per-window distortion sums (BO sliding, EO aligned) and minimum.
// Latency: window 1 cycle after accept; best 2 cycles after the last accept.
// in_ready high only in RUN; bubbles on in_valid stall the pass without side effects.
module sao_band_window_search import sao_pkg::*; #(
  parameter int  DIST_W       = 21,
  parameter int  WIN          = 4,
  parameter int  NUM_BAND     = 32,
  parameter int  NUM_EO_CLASS = 4,
  localparam int SUM_W        = sao_sum_w(DIST_W, WIN),
  localparam int POS_W        = sao_pos_w(NUM_BAND, NUM_EO_CLASS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DIST_W-1:0] in_dist,
  output logic                     in_ready,
  output logic                     win_valid,
  output logic signed [SUM_W-1:0]  win_sum,
  output logic [POS_W-1:0]         win_pos,
  output logic                     best_valid,
  output logic signed [SUM_W-1:0]  best_sum,
  output logic [POS_W-1:0]         best_pos,
  output logic                     busy
);

  localparam int N_BO  = NUM_BAND;
  localparam int N_EO  = NUM_EO_CLASS * WIN;
  localparam int N_MAX = (N_BO > N_EO) ? N_BO : N_EO;
  localparam int IDX_W = $clog2(N_MAX + 1);

  sao_state_e              state_q;
  sao_mode_e               mode_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    first_q;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    win_valid_q;
  logic [POS_W-1:0]        win_pos_q;
  logic                    best_valid_q;
  logic signed [SUM_W-1:0] best_sum_q;
  logic [POS_W-1:0]        best_pos_q;

  logic                    accept;
  logic                    start_clr;
  logic                    emit_d;
  logic                    last_d;
  logic [POS_W-1:0]        pos_d;

  // in_ready_q is high only in RUN, so it doubles as the state qualifier.
  assign accept    = in_valid && in_ready_q;
  assign start_clr = (state_q == ST_IDLE) && start;

  sao_win_sum #(
    .DIST_W (DIST_W),
    .WIN    (WIN)
  ) u_win_sum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_clr),
    .shift_i (accept),
    .din_i   (in_dist),
    .sum_o   (win_sum)
  );

  // Decode whether the current accept closes a window, its position, and end of pass.
  always_comb begin
    emit_d = 1'b0;
    pos_d  = '0;
    last_d = 1'b0;
    if (mode_q == SAO_BO) begin
      emit_d = idx_q >= IDX_W'(WIN - 1);
      pos_d  = POS_W'(idx_q - IDX_W'(WIN - 1));
      last_d = idx_q == IDX_W'(N_BO - 1);
    end else begin
      emit_d = (idx_q % IDX_W'(WIN)) == IDX_W'(WIN - 1);
      pos_d  = POS_W'(idx_q / IDX_W'(WIN));
      last_d = idx_q == IDX_W'(N_EO - 1);
    end
  end

  // Pass FSM with registered strobes, sample counter and running minimum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= SAO_BO;
      idx_q        <= '0;
      first_q      <= 1'b1;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      win_valid_q  <= 1'b0;
      win_pos_q    <= '0;
      best_valid_q <= 1'b0;
      best_sum_q   <= '0;
      best_pos_q   <= '0;
    end else begin
      win_valid_q  <= 1'b0;
      best_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            mode_q     <= sao_mode_e'(mode);
            idx_q      <= '0;
            first_q    <= 1'b1;
            best_sum_q <= '0;
            best_pos_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            idx_q       <= idx_q + 1'b1;
            win_valid_q <= emit_d;
            if (emit_d) begin
              win_pos_q <= pos_d;
            end
            if (last_d) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_DONE;
          best_valid_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A window strobe never coincides with IDLE, so this cannot race the start clear.
      // Strict less-than keeps the earlier (lower) position on ties.
      if (win_valid_q && (first_q || (win_sum < best_sum_q))) begin
        best_sum_q <= win_sum;
        best_pos_q <= win_pos_q;
        first_q    <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign win_valid  = win_valid_q;
  assign win_pos    = win_pos_q;
  assign best_valid = best_valid_q;
  assign best_sum   = best_sum_q;
  assign best_pos   = best_pos_q;

endmodule

// File: tb/tb_sao_band_window_search.sv
// Bench for sao_band_window_search: directed passes, expected windows and best
// results queued at stimulus time, popped and compared by a negedge monitor.
module tb_sao_band_window_search;

  localparam int DIST_W       = 21;
  localparam int WIN          = 4;
  localparam int NUM_BAND     = 32;
  localparam int NUM_EO_CLASS = 4;
  localparam int SUM_W        = 23;
  localparam int POS_W        = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     mode;
  logic                     in_valid;
  logic signed [DIST_W-1:0] in_dist;
  logic                     in_ready;
  logic                     win_valid;
  logic signed [SUM_W-1:0]  win_sum;
  logic [POS_W-1:0]         win_pos;
  logic                     best_valid;
  logic signed [SUM_W-1:0]  best_sum;
  logic [POS_W-1:0]         best_pos;
  logic                     busy;

  sao_band_window_search #(
    .DIST_W       (DIST_W),
    .WIN          (WIN),
    .NUM_BAND     (NUM_BAND),
    .NUM_EO_CLASS (NUM_EO_CLASS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_dist    (in_dist),
    .in_ready   (in_ready),
    .win_valid  (win_valid),
    .win_sum    (win_sum),
    .win_pos    (win_pos),
    .best_valid (best_valid),
    .best_sum   (best_sum),
    .best_pos   (best_pos),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sum;
    int     pos;
  } win_t;

  win_t win_q[$];
  win_t best_q[$];
  int   best_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nwin   = 0;

  logic signed [DIST_W-1:0] stim [64];
  int eo_v [16] = '{1, 2, 1, 1, -1, -1, -1, 0, -3, 0, 0, 0, 7, 0, 0, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a window or a best result.
  always @(negedge clk) begin : mon
    win_t e;
    int   ec;
    if (win_valid) begin
      nwin++;
      if (win_q.size() == 0) begin
        chk("win_unexpected", 1, 0);
      end else begin
        e = win_q.pop_front();
        chk("win_sum", win_sum, e.sum);
        chk("win_pos", win_pos, e.pos);
      end
    end
    if (best_valid) begin
      if (best_q.size() == 0 || best_cyc_q.size() == 0) begin
        chk("best_unexpected", 1, 0);
      end else begin
        e  = best_q.pop_front();
        ec = best_cyc_q.pop_front();
        chk("best_sum", best_sum, e.sum);
        chk("best_pos", best_pos, e.pos);
        chk("best_cycle", cyc, ec);
      end
    end
  end

  // kind: 0 BO dip, 1 all zero, 2 EO classes, 3 most negative, 4 most positive
  task automatic fill(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       stim[i] = (i >= 5 && i <= 8) ? -21'sd100 : 21'sd10;
        1:       stim[i] = '0;
        2:       stim[i] = (i < 16) ? DIST_W'(eo_v[i]) : '0;
        3:       stim[i] = DIST_W'(-(1 << 20));
        default: stim[i] = DIST_W'((1 << 20) - 1);
      endcase
    end
  endtask

  // Drives one pass of n samples; full=0 stops after n accepts without finishing.
  task automatic run_pass(input string tag, input bit md, input int n, input bit bubbles,
                          input bit full, input int exp_nwin, input longint exp_bsum,
                          input int exp_bpos);
    win_t   e;
    longint s;
    int     i;
    int     g;
    bit     ready_ok;
    nwin     = 0;
    ready_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    if (full) begin
      e.sum = exp_bsum;
      e.pos = exp_bpos;
      best_q.push_back(e);
    end
    i = 0;
    g = 0;
    while (i < n) begin
      if (bubbles && (g % 2 == 1)) begin
        in_valid = 1'b0;
        in_dist  = 21'sh0A5A5;
      end else begin
        in_valid = 1'b1;
        in_dist  = stim[i];
        if (!in_ready) ready_ok = 1'b0;
        if (md ? (i % WIN == WIN - 1) : (i >= WIN - 1)) begin
          s = 0;
          for (int k = 0; k < WIN; k++) s += stim[i-k];
          e.sum = s;
          e.pos = md ? i / WIN : i - WIN + 1;
          win_q.push_back(e);
        end
        if (full && i == n - 1) best_cyc_q.push_back(cyc + 2);
        i++;
      end
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_ready_run"}, ready_ok, 1);
    if (full) begin
      chk({tag, "_ready_drain"}, in_ready, 0);
      for (int w = 0; w < 10 && busy; w++) @(negedge clk);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_win_left"}, win_q.size(), 0);
      chk({tag, "_best_left"}, best_q.size(), 0);
      chk({tag, "_nwin"}, nwin, exp_nwin);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_sum"}, win_sum, 0);
    chk({tag, "_win_pos"}, win_pos, 0);
    chk({tag, "_best_valid"}, best_valid, 0);
    chk({tag, "_best_sum"}, best_sum, 0);
    chk({tag, "_best_pos"}, best_pos, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_dist  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // BO dip: bands 5..8 at -100, best window starts at band 5 with -400.
    fill(0);
    run_pass("bo_dip", 1'b0, NUM_BAND, 1'b0, 1'b1, 29, -400, 5);

    // All zero: every window ties, lowest position must win.
    fill(1);
    run_pass("bo_tie", 1'b0, NUM_BAND, 1'b0, 1'b1, 29, 0, 0);

    // EO: class sums {5,-3,-3,7}, tie between classes 1 and 2 keeps class 1.
    fill(2);
    run_pass("eo", 1'b1, NUM_EO_CLASS * WIN, 1'b0, 1'b1, 4, -3, 1);

    // Same dip with a bubble every other cycle.
    fill(0);
    run_pass("bubble", 1'b0, NUM_BAND, 1'b1, 1'b1, 29, -400, 5);

    // Reset after 10 accepts: windows 0..6 already emitted, then everything clears.
    fill(0);
    run_pass("partial", 1'b0, 10, 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    chk("midrst_win_left", win_q.size(), 0);
    chk("midrst_nwin", nwin, 7);
    run_pass("after_rst", 1'b0, NUM_BAND, 1'b0, 1'b1, 29, -400, 5);

    // Extremes: sums reach -2^22 and 4*(2^20-1) without wrapping.
    fill(3);
    run_pass("neg_ext", 1'b0, NUM_BAND, 1'b0, 1'b1, 29, -4194304, 0);
    fill(4);
    run_pass("pos_ext", 1'b0, NUM_BAND, 1'b0, 1'b1, 29, 4194300, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
